// File: rtl/fm_add_rd_seq.sv
// fm_add_rd_seq -- read sequencer for the feature-map-add BRAM pair.
//
// On an accepted start the block reads bank0 (operand A) and bank1 (operand B)
// at the same address, walking start_addr upward with wrap at BRAM_DEPTH-1,
// adds the two words lane by lane and streams the sums out on a valid/ready
// port through a 2-entry output FIFO. Reads are only issued when every read
// already in flight is guaranteed a slot, so backpressure never drops data.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   start, start_addr, len     command (sampled only in IDLE; len clamped to BRAM_DEPTH)
//   busy, done                 command status; done is a 1-cycle pulse
//   bram0_en/addr/dout         bank0 read port (data 1 cycle after en)
//   bram1_en/addr/dout         bank1 read port (en/addr mirror bank0)
//   m_valid, m_ready           output handshake
//   m_data, m_last             lane-wise A+B, final-beat marker
//
// Configuration
//   FM_ADD_SAT_EN  defined: signed saturating lane add with one extra register
//                  stage (first m_valid 3 cycles after first read).
//                  undefined: wrap-around lane add.
module fm_add_rd_seq #(
   parameter int BRAM_DATA_WIDTH = 64,
   parameter int BRAM_DEPTH      = 64,
   parameter int BRAM_ADDR_WIDTH = $clog2(BRAM_DEPTH),
   parameter int LANE_WIDTH      = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       start,
   input  logic [BRAM_ADDR_WIDTH-1:0] start_addr,
   input  logic [BRAM_ADDR_WIDTH:0]   len,
   output logic                       busy,
   output logic                       done,
   output logic                       bram0_en,
   output logic [BRAM_ADDR_WIDTH-1:0] bram0_addr,
   input  logic [BRAM_DATA_WIDTH-1:0] bram0_dout,
   output logic                       bram1_en,
   output logic [BRAM_ADDR_WIDTH-1:0] bram1_addr,
   input  logic [BRAM_DATA_WIDTH-1:0] bram1_dout,
   output logic                       m_valid,
   input  logic                       m_ready,
   output logic [BRAM_DATA_WIDTH-1:0] m_data,
   output logic                       m_last
);

   localparam int NUM_LANES = BRAM_DATA_WIDTH / LANE_WIDTH;
   localparam int LEN_W     = BRAM_ADDR_WIDTH + 1;
   localparam logic [LEN_W-1:0]           DEPTH_LEN = LEN_W'(BRAM_DEPTH);
   localparam logic [BRAM_ADDR_WIDTH-1:0] LAST_ADDR = BRAM_ADDR_WIDTH'(BRAM_DEPTH - 1);
`ifdef FM_ADD_SAT_EN
   // FIFO slots plus the saturation register, which can hold a beat under stall.
   localparam logic [2:0] CAPACITY = 3'd3;
`else
   localparam logic [2:0] CAPACITY = 3'd2;
`endif

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   function automatic logic [BRAM_DATA_WIDTH-1:0] lane_add(
      input logic [BRAM_DATA_WIDTH-1:0] a,
      input logic [BRAM_DATA_WIDTH-1:0] b
   );
      logic [BRAM_DATA_WIDTH-1:0] r;
      logic [LANE_WIDTH-1:0]      la;
      logic [LANE_WIDTH-1:0]      lb;
`ifdef FM_ADD_SAT_EN
      logic [LANE_WIDTH:0]        s;
`endif
      r = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         la = a[i*LANE_WIDTH +: LANE_WIDTH];
         lb = b[i*LANE_WIDTH +: LANE_WIDTH];
`ifdef FM_ADD_SAT_EN
         s = {la[LANE_WIDTH-1], la} + {lb[LANE_WIDTH-1], lb};
         // The two top bits disagree only when the true sum left the lane range.
         if (s[LANE_WIDTH] != s[LANE_WIDTH-1])
            r[i*LANE_WIDTH +: LANE_WIDTH] = s[LANE_WIDTH] ? {1'b1, {(LANE_WIDTH-1){1'b0}}}
                                                          : {1'b0, {(LANE_WIDTH-1){1'b1}}};
         else
            r[i*LANE_WIDTH +: LANE_WIDTH] = s[LANE_WIDTH-1:0];
`else
         r[i*LANE_WIDTH +: LANE_WIDTH] = la + lb;
`endif
      end
      return r;
   endfunction

   state_t                     state_q, state_d;
   logic [BRAM_ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [LEN_W-1:0]           rd_left_q, rd_left_d;
   logic                       busy_q, busy_d;
   logic                       done_q, done_d;
   logic                       rd_vld_q, rd_vld_d;
   logic                       rd_last_q, rd_last_d;
`ifdef FM_ADD_SAT_EN
   logic                       sat_vld_q, sat_vld_d;
   logic                       sat_last_q, sat_last_d;
   logic [BRAM_DATA_WIDTH-1:0] sat_data_q, sat_data_d;
`endif
   logic [BRAM_DATA_WIDTH-1:0] fifo_data_q [2];
   logic [BRAM_DATA_WIDTH-1:0] fifo_data_d [2];
   logic [1:0]                 fifo_last_q, fifo_last_d;
   logic                       wr_ptr_q, wr_ptr_d;
   logic                       rd_ptr_q, rd_ptr_d;
   logic [1:0]                 count_q, count_d;

   logic                       issue, push, pop, push_last;
   logic [BRAM_DATA_WIDTH-1:0] push_data;
   logic [2:0]                 occupancy;

   // Datapath: credit check, capture/sum stage, FIFO bookkeeping.
   always_comb begin
      // NOTE: every signal written here gets a default first so no latch is inferred.
      pop = (count_q != 2'd0) && m_ready;
`ifdef FM_ADD_SAT_EN
      push      = sat_vld_q && ((count_q != 2'd2) || pop);
      push_data = sat_data_q;
      push_last = sat_last_q;
      occupancy = 3'(count_q) + 3'(sat_vld_q) + 3'(rd_vld_q);
`else
      push      = rd_vld_q;
      push_data = lane_add(bram0_dout, bram1_dout);
      push_last = rd_last_q;
      occupancy = 3'(count_q) + 3'(rd_vld_q);
`endif
      // A slot being popped this cycle is already free for the next read.
      issue = (state_q == S_RUN) && (occupancy < (CAPACITY + 3'(pop)));

      rd_vld_d  = issue;
      rd_last_d = issue && (rd_left_q == LEN_W'(1));
`ifdef FM_ADD_SAT_EN
      sat_vld_d  = rd_vld_q | (sat_vld_q & ~push);
      sat_data_d = rd_vld_q ? lane_add(bram0_dout, bram1_dout) : sat_data_q;
      sat_last_d = rd_vld_q ? rd_last_q : sat_last_q;
`endif
      fifo_data_d = fifo_data_q;
      fifo_last_d = fifo_last_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      if (push) begin
         fifo_data_d[wr_ptr_q] = push_data;
         fifo_last_d[wr_ptr_q] = push_last;
         wr_ptr_d              = ~wr_ptr_q;
      end
      if (pop) rd_ptr_d = ~rd_ptr_q;
      count_d = count_q + 2'(push) - 2'(pop);
   end

   // Command FSM and read address generation.
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      rd_left_d = rd_left_q;
      unique case (state_q)
         S_IDLE: if (start) begin
            addr_d    = start_addr;
            rd_left_d = (len > DEPTH_LEN) ? DEPTH_LEN : len;
            state_d   = (len == '0) ? S_DONE : S_RUN;
         end
         S_RUN: if (issue) begin
            addr_d    = (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;
            rd_left_d = rd_left_q - 1'b1;
            if (rd_left_q == LEN_W'(1)) state_d = S_DRAIN;
         end
         S_DRAIN: if (m_valid && m_ready && m_last) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d != S_IDLE);
      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         addr_q      <= '0;
         rd_left_q   <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         rd_vld_q    <= 1'b0;
         rd_last_q   <= 1'b0;
`ifdef FM_ADD_SAT_EN
         sat_vld_q   <= 1'b0;
         sat_last_q  <= 1'b0;
         sat_data_q  <= '0;
`endif
         // NOTE: the two FIFO words are reset because the head drives m_data,
         // which must read zero out of reset; larger memories would not be.
         fifo_data_q <= '{default: '0};
         fifo_last_q <= '0;
         wr_ptr_q    <= 1'b0;
         rd_ptr_q    <= 1'b0;
         count_q     <= '0;
      end else begin
         // NOTE: non-blocking so every register samples the pre-edge values.
         state_q     <= state_d;
         addr_q      <= addr_d;
         rd_left_q   <= rd_left_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         rd_vld_q    <= rd_vld_d;
         rd_last_q   <= rd_last_d;
`ifdef FM_ADD_SAT_EN
         sat_vld_q   <= sat_vld_d;
         sat_last_q  <= sat_last_d;
         sat_data_q  <= sat_data_d;
`endif
         fifo_data_q <= fifo_data_d;
         fifo_last_q <= fifo_last_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
      end
   end

   assign busy       = busy_q;
   assign done       = done_q;
   assign bram0_en   = issue;
   assign bram1_en   = issue;
   assign bram0_addr = addr_q;
   assign bram1_addr = addr_q;
   assign m_valid    = (count_q != 2'd0);
   assign m_data     = fifo_data_q[rd_ptr_q];
   assign m_last     = m_valid & fifo_last_q[rd_ptr_q];

endmodule

// File: tb/tb_fm_add_rd_seq.sv
// Scoreboard bench for fm_add_rd_seq: commands push expected addresses and
// beats (from a lane-arithmetic reference model over bank arrays) into queues;
// a negedge monitor pops and compares whenever the DUT reads or hands off a beat.
module tb_fm_add_rd_seq;

   localparam int DW = 64;
   localparam int DEPTH = 64;
   localparam int AW = 6;
`ifdef FM_ADD_SAT_EN
   localparam int LAT = 3;
   localparam int OUT_LIM = 3;
`else
   localparam int LAT = 2;
   localparam int OUT_LIM = 2;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [AW-1:0] start_addr = '0;
   logic [AW:0]   len = '0;
   logic          busy, done;
   logic          bram0_en, bram1_en;
   logic [AW-1:0] bram0_addr, bram1_addr;
   logic [DW-1:0] bram0_dout = '0, bram1_dout = '0;
   logic          m_valid, m_last;
   logic          m_ready = 1'b1;
   logic [DW-1:0] m_data;

   fm_add_rd_seq dut (
      .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr), .len(len),
      .busy(busy), .done(done),
      .bram0_en(bram0_en), .bram0_addr(bram0_addr), .bram0_dout(bram0_dout),
      .bram1_en(bram1_en), .bram1_addr(bram1_addr), .bram1_dout(bram1_dout),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
   );

   always #5 clk = ~clk;

   typedef struct { logic [DW-1:0] data; logic last; } beat_t;

   logic [DW-1:0] bank0 [DEPTH];
   logic [DW-1:0] bank1 [DEPTH];
   beat_t exp_q[$];
   int    exp_addr_q[$];

   int total = 0;
   int bad = 0;
   int rdy_mode = 0;

   // Monitor-owned observations.
   int ncyc = 0, start_ncyc = -1, first_en = -1, first_v = -1;
   int last_hs = -1, done_ncyc = -1, done_cnt = 0, hs_cnt = 0;
   int issued = 0, accepted = 0;
   logic          prev_stall = 1'b0, prev_last = 1'b0;
   logic [DW-1:0] prev_data = '0;

   task automatic check(input string name, input logic ok,
                        input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference lane add: signed integer sum, saturated or wrapped to 16 bits.
   function automatic logic [DW-1:0] ref_sum(input logic [DW-1:0] a, input logic [DW-1:0] b);
      logic [DW-1:0] r;
      int s;
      r = '0;
      for (int i = 0; i < DW / 16; i++) begin
         s = int'($signed(a[i*16 +: 16])) + int'($signed(b[i*16 +: 16]));
`ifdef FM_ADD_SAT_EN
         if (s > 32767) s = 32767;
         if (s < -32768) s = -32768;
`endif
         r[i*16 +: 16] = 16'(s);
      end
      return r;
   endfunction

   // Bank read-port model: data one cycle after enable.
   always @(posedge clk) begin
      if (bram0_en) bram0_dout <= bank0[bram0_addr];
      if (bram1_en) bram1_dout <= bank1[bram1_addr];
   end

   // Sink ready pattern: 0 = always ready, 1 = 1,0,0 repeating, 2 = random.
   initial begin
      int ph = 0;
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            1:       m_ready = (ph % 3 == 0);
            2:       m_ready = 1'($urandom_range(0, 1));
            default: m_ready = 1'b1;
         endcase
         ph++;
      end
   end

   // Monitor: sampled at negedge, away from the active edge.
   always @(negedge clk) begin
      beat_t b;
      int    a;
      logic  hs;
      ncyc++;
      if (!rst_n) begin
         prev_stall = 1'b0;
         issued = 0;
         accepted = 0;
      end else begin
         hs = m_valid && m_ready;
         if (start && !busy) begin
            start_ncyc = ncyc; first_en = -1; first_v = -1; hs_cnt = 0; last_hs = -1;
         end
         if (hs) accepted++;
         if (bram0_en || bram1_en) begin
            check("en_match", bram1_en == bram0_en, 64'(bram1_en), 64'(bram0_en));
            check("addr_match", bram1_addr == bram0_addr, 64'(bram1_addr), 64'(bram0_addr));
            if (first_en < 0) first_en = ncyc;
            issued++;
            check("read_expected", exp_addr_q.size() != 0, 64'(bram0_addr), 64'(0));
            if (exp_addr_q.size() != 0) begin
               a = exp_addr_q.pop_front();
               check("read_addr", int'(bram0_addr) == a, 64'(bram0_addr), 64'(a));
            end
            check("outstanding", (issued - accepted) <= OUT_LIM, 64'(issued - accepted), 64'(OUT_LIM));
         end
         if (prev_stall) begin
            check("stall_valid", m_valid == 1'b1, 64'(m_valid), 64'(1));
            check("stall_data", m_data == prev_data, m_data, prev_data);
            check("stall_last", m_last == prev_last, 64'(m_last), 64'(prev_last));
         end
         if (m_valid && first_v < 0) first_v = ncyc;
         if (hs) begin
            hs_cnt++;
            check("beat_expected", exp_q.size() != 0, m_data, 64'(0));
            if (exp_q.size() != 0) begin
               b = exp_q.pop_front();
               check("beat_data", m_data == b.data, m_data, b.data);
               check("beat_last", m_last == b.last, 64'(m_last), 64'(b.last));
            end
            if (m_last) last_hs = ncyc;
         end
         if (done) begin
            done_ncyc = ncyc;
            done_cnt++;
         end
         prev_stall = m_valid && !m_ready;
         prev_data  = m_data;
         prev_last  = m_last;
      end
   end

   task automatic fill_random();
      for (int a = 0; a < DEPTH; a++) begin
         bank0[a] = {$urandom, $urandom};
         bank1[a] = {$urandom, $urandom};
      end
   endtask

   task automatic check_reset_vals();
      check("rst_busy", busy == 1'b0, 64'(busy), 0);
      check("rst_done", done == 1'b0, 64'(done), 0);
      check("rst_en", {bram0_en, bram1_en} == 2'b00, 64'({bram0_en, bram1_en}), 0);
      check("rst_addr", {bram0_addr, bram1_addr} == '0, 64'({bram0_addr, bram1_addr}), 0);
      check("rst_valid", m_valid == 1'b0, 64'(m_valid), 0);
      check("rst_last", m_last == 1'b0, 64'(m_last), 0);
      check("rst_data", m_data == '0, m_data, 0);
   endtask

   task automatic run_cmd(input int sa, input int ln, input int mode, input bit lat_chk, input bit poke);
      int n, d0, a;
      rdy_mode = mode;
      n = (ln > DEPTH) ? DEPTH : ln;
      for (int k = 0; k < n; k++) begin
         a = (sa + k) % DEPTH;
         exp_addr_q.push_back(a);
         exp_q.push_back('{data: ref_sum(bank0[a], bank1[a]), last: (k == n - 1)});
      end
      d0 = done_cnt;
      @(posedge clk); #1;
      start = 1'b1; start_addr = AW'(sa); len = (AW + 1)'(ln);
      @(posedge clk); #1;
      start = 1'b0;
      if (poke) begin
         repeat (2) @(posedge clk);
         #1; start = 1'b1; start_addr = 6'd5; len = 7'd3;
         @(posedge clk); #1; start = 1'b0;
      end
      for (int i = 0; i < 800; i++) begin
         @(posedge clk);
         if (done_cnt != d0) break;
      end
      check("done_seen", done_cnt != d0, 64'(done_cnt), 64'(d0 + 1));
      check("single_done", done_cnt - d0 <= 1, 64'(done_cnt - d0), 64'(1));
      @(negedge clk);
      check("busy_after_done", busy == 1'b0, 64'(busy), 0);
      check("beat_count", hs_cnt == n, 64'(hs_cnt), 64'(n));
      check("beats_left", exp_q.size() == 0, 64'(exp_q.size()), 0);
      check("reads_left", exp_addr_q.size() == 0, 64'(exp_addr_q.size()), 0);
      exp_q.delete();
      exp_addr_q.delete();
      if (n == 0) begin
         check("len0_done_lat", (done_ncyc - start_ncyc) inside {[1:2]}, 64'(done_ncyc - start_ncyc), 64'(2));
         check("len0_no_read", first_en < 0, 64'(first_en), 64'(-1));
         check("len0_no_valid", first_v < 0, 64'(first_v), 64'(-1));
      end else if (lat_chk) begin
         check("first_read_lat", first_en - start_ncyc == 1, 64'(first_en - start_ncyc), 64'(1));
         check("first_valid_lat", first_v - first_en == LAT, 64'(first_v - first_en), 64'(LAT));
         check("throughput", last_hs - first_v == n - 1, 64'(last_hs - first_v), 64'(n - 1));
         check("done_after_last", done_ncyc - last_hs == 1, 64'(done_ncyc - last_hs), 64'(1));
      end
   endtask

   initial begin
      int d0;
      #500000;
      $display("FAIL watchdog: got=timeout want=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int d0;
      #22;
      check_reset_vals();
      @(posedge clk); #1; rst_n = 1'b1;

      // Basic: A[k]=k, B[k]=2k in every lane.
      for (int k = 0; k < DEPTH; k++) begin
         bank0[k] = {4{16'(k)}};
         bank1[k] = {4{16'(2 * k)}};
      end
      run_cmd(0, 8, 0, 1, 0);

      fill_random();
      run_cmd(62, 4, 0, 1, 0);      // address wrap
      run_cmd(10, 16, 1, 0, 0);     // backpressure 1,0,0
      run_cmd(3, 0, 0, 1, 0);       // empty command
      run_cmd(30, 100, 2, 0, 0);    // clamped to 64 beats
      run_cmd(5, 12, 0, 1, 1);      // start pulsed while busy

      // Lane overflow corner cases.
      bank0[40] = {16'h7FFF, 16'h8000, 16'h8000, 16'h1234};
      bank1[40] = {16'h0001, 16'hFFFF, 16'h8000, 16'h0001};
      bank0[41] = {16'h8001, 16'h7FFF, 16'hFFFF, 16'h4000};
      bank1[41] = {16'h8001, 16'h7FFF, 16'h0001, 16'h4000};
      run_cmd(40, 2, 0, 1, 0);

      for (int r = 0; r < 6; r++) begin
         fill_random();
         run_cmd(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 80)),
                 int'($urandom_range(0, 2)), 0, 0);
      end

      // Reset mid-command after beat 3 of len=10.
      fill_random();
      rdy_mode = 0;
      for (int k = 0; k < 10; k++) begin
         exp_addr_q.push_back(7 + k);
         exp_q.push_back('{data: ref_sum(bank0[7 + k], bank1[7 + k]), last: (k == 9)});
      end
      @(posedge clk); #1; start = 1'b1; start_addr = 6'd7; len = 7'd10;
      @(posedge clk); #1; start = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(posedge clk);
         if (hs_cnt >= 3) break;
      end
      check("reset_pre_beats", hs_cnt >= 3, 64'(hs_cnt), 64'(3));
      #1; rst_n = 1'b0;
      #2;
      check_reset_vals();
      exp_q.delete();
      exp_addr_q.delete();
      d0 = done_cnt;
      repeat (2) @(posedge clk);
      #1; rst_n = 1'b1;
      repeat (3) @(posedge clk);
      check("reset_no_done", done_cnt == d0, 64'(done_cnt), 64'(d0));
      run_cmd(20, 5, 0, 1, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
